// File: rtl/wb_stage_pkg.sv
// Shared bus and control definitions for the write-back stage and the decoder.
// Also provides the ADDR_BUS range macro used for PC ports.
`ifndef ADDR_BUS
`define ADDR_BUS 31:0
`endif

package wb_stage_pkg;

    localparam int unsigned RD_W     = 5;
    localparam int unsigned WD_SEL_W = 2;
    localparam int unsigned DM_W     = 3;

    // Write-back source select
    localparam logic [WD_SEL_W-1:0] WB_SEL_ALU = 2'b00;
    localparam logic [WD_SEL_W-1:0] WB_SEL_MEM = 2'b01;
    localparam logic [WD_SEL_W-1:0] WB_SEL_PC4 = 2'b10;
    localparam logic [WD_SEL_W-1:0] WB_SEL_IMM = 2'b11;

    // Load funct3 codes
    localparam logic [DM_W-1:0] DM_LB  = 3'b000;
    localparam logic [DM_W-1:0] DM_LH  = 3'b001;
    localparam logic [DM_W-1:0] DM_LW  = 3'b010;
    localparam logic [DM_W-1:0] DM_LBU = 3'b100;
    localparam logic [DM_W-1:0] DM_LHU = 3'b101;

endpackage

// File: rtl/wb_load_ext.sv
// Combinational load formatter: selects byte/halfword by offset and extends it.
module wb_load_ext
    import wb_stage_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] rdata_i,
    input  logic [1:0]      off_i,
    input  logic [DM_W-1:0] dm_type_i,
    output logic [XLEN-1:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = rdata_i[{off_i, 3'b000} +: 8];
    assign half_sel = rdata_i[{off_i[1], 4'b0000} +: 16];

    always_comb begin
        data_o = rdata_i;
        case (dm_type_i)
            DM_LB:   data_o = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            DM_LBU:  data_o = {{(XLEN-8){1'b0}}, byte_sel};
            DM_LH:   data_o = {{(XLEN-16){half_sel[15]}}, half_sel};
            DM_LHU:  data_o = {{(XLEN-16){1'b0}}, half_sel};
            default: data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// MEM/WB pipeline register, write-back mux, RF write port and retired-instruction counter.
// Sub-word load formatting is enabled by defining WB_LOAD_EXT_EN.
module wb_stage
    import wb_stage_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall,
    input  logic                flush,
    input  logic                mem_valid,
    input  logic [`ADDR_BUS]    mem_pc,
    input  logic [RD_W-1:0]     mem_rd,
    input  logic                mem_reg_wr,
    input  logic [WD_SEL_W-1:0] mem_wd_sel,
    input  logic [DM_W-1:0]     mem_dm_type,
    input  logic [XLEN-1:0]     mem_alu_out,
    input  logic [XLEN-1:0]     mem_rdata,
    input  logic [XLEN-1:0]     mem_imm,
    output logic                RFWr,
    output logic [RD_W-1:0]     A3,
    output logic [XLEN-1:0]     WD,
    output logic [`ADDR_BUS]    pc,
    output logic                wb_fwd_valid,
    output logic [RD_W-1:0]     wb_fwd_rd,
    output logic [XLEN-1:0]     wb_fwd_data,
    output logic [CNT_W-1:0]    instret
);

    logic                valid_q,   valid_d;
    logic [`ADDR_BUS]    pc_q,      pc_d;
    logic [RD_W-1:0]     rd_q,      rd_d;
    logic                reg_wr_q,  reg_wr_d;
    logic [WD_SEL_W-1:0] wd_sel_q,  wd_sel_d;
    logic [XLEN-1:0]     alu_out_q, alu_out_d;
    logic [XLEN-1:0]     rdata_q,   rdata_d;
    logic [XLEN-1:0]     imm_q,     imm_d;
    logic [CNT_W-1:0]    instret_q, instret_d;
    logic [XLEN-1:0]     load_data;
    logic [XLEN-1:0]     wd_c;

    // Next-state: flush wins over stall; flush only needs to clear valid
    always_comb begin
        valid_d   = valid_q;
        pc_d      = pc_q;
        rd_d      = rd_q;
        reg_wr_d  = reg_wr_q;
        wd_sel_d  = wd_sel_q;
        alu_out_d = alu_out_q;
        rdata_d   = rdata_q;
        imm_d     = imm_q;
        instret_d = instret_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (!stall) begin
            valid_d   = mem_valid;
            pc_d      = mem_pc;
            rd_d      = mem_rd;
            reg_wr_d  = mem_reg_wr;
            wd_sel_d  = mem_wd_sel;
            alu_out_d = mem_alu_out;
            rdata_d   = mem_rdata;
            imm_d     = mem_imm;
        end
        if (valid_q && !stall) begin
            instret_d = instret_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q   <= 1'b0;
            pc_q      <= '0;
            rd_q      <= '0;
            reg_wr_q  <= 1'b0;
            wd_sel_q  <= '0;
            alu_out_q <= '0;
            rdata_q   <= '0;
            imm_q     <= '0;
            instret_q <= '0;
        end else begin
            valid_q   <= valid_d;
            pc_q      <= pc_d;
            rd_q      <= rd_d;
            reg_wr_q  <= reg_wr_d;
            wd_sel_q  <= wd_sel_d;
            alu_out_q <= alu_out_d;
            rdata_q   <= rdata_d;
            imm_q     <= imm_d;
            instret_q <= instret_d;
        end
    end

`ifdef WB_LOAD_EXT_EN
    logic [DM_W-1:0] dm_type_q, dm_type_d;

    always_comb begin
        dm_type_d = dm_type_q;
        if (!flush && !stall) begin
            dm_type_d = mem_dm_type;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dm_type_q <= '0;
        end else begin
            dm_type_q <= dm_type_d;
        end
    end

    wb_load_ext #(
        .XLEN (XLEN)
    ) u_load_ext (
        .rdata_i   (rdata_q),
        .off_i     (alu_out_q[1:0]),
        .dm_type_i (dm_type_q),
        .data_o    (load_data)
    );
`else
    logic unused_dm_type;
    assign unused_dm_type = ^mem_dm_type;
    assign load_data      = rdata_q;
`endif

    // Write-back source mux
    always_comb begin
        wd_c = alu_out_q;
        case (wd_sel_q)
            WB_SEL_ALU: wd_c = alu_out_q;
            WB_SEL_MEM: wd_c = load_data;
            WB_SEL_PC4: wd_c = XLEN'(pc_q + 32'd4);
            WB_SEL_IMM: wd_c = imm_q;
            default:    wd_c = alu_out_q;
        endcase
    end

    assign RFWr         = valid_q & reg_wr_q & (rd_q != '0);
    assign A3           = rd_q;
    assign WD           = wd_c;
    assign pc           = pc_q;
    assign wb_fwd_valid = RFWr;
    assign wb_fwd_rd    = A3;
    assign wb_fwd_data  = WD;
    assign instret      = instret_q;

endmodule

// File: tb/tb_wb_stage.sv
// Directed self-checking bench for wb_stage; expectations follow WB_LOAD_EXT_EN.
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        rst, stall, flush, mem_valid, mem_reg_wr;
    logic [31:0] mem_pc, mem_alu_out, mem_rdata, mem_imm;
    logic [4:0]  mem_rd;
    logic [1:0]  mem_wd_sel;
    logic [2:0]  mem_dm_type;
    logic        RFWr, wb_fwd_valid;
    logic [4:0]  A3, wb_fwd_rd;
    logic [31:0] WD, pc, wb_fwd_data;
    logic [63:0] instret;

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_cnt;

    always #5 clk = ~clk;

    wb_stage #(.XLEN(32), .CNT_W(64)) dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .flush        (flush),
        .mem_valid    (mem_valid),
        .mem_pc       (mem_pc),
        .mem_rd       (mem_rd),
        .mem_reg_wr   (mem_reg_wr),
        .mem_wd_sel   (mem_wd_sel),
        .mem_dm_type  (mem_dm_type),
        .mem_alu_out  (mem_alu_out),
        .mem_rdata    (mem_rdata),
        .mem_imm      (mem_imm),
        .RFWr         (RFWr),
        .A3           (A3),
        .WD           (WD),
        .pc           (pc),
        .wb_fwd_valid (wb_fwd_valid),
        .wb_fwd_rd    (wb_fwd_rd),
        .wb_fwd_data  (wb_fwd_data),
        .instret      (instret)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] p, input logic [4:0] rd,
                         input logic wr, input logic [1:0] sel, input logic [2:0] dm,
                         input logic [31:0] alu, input logic [31:0] rdat, input logic [31:0] imm);
        mem_valid = v; mem_pc = p; mem_rd = rd; mem_reg_wr = wr; mem_wd_sel = sel;
        mem_dm_type = dm; mem_alu_out = alu; mem_rdata = rdat; mem_imm = imm;
    endtask

    task automatic test_reset();
        rst = 1'b1; stall = 1'b0; flush = 1'b0;
        drive(1'b1, 32'h40, 5'd7, 1'b1, 2'b00, 3'b010, 32'h99, 32'h0, 32'h0);
        tick(); tick();
        checks++; if (RFWr !== 1'b0) begin errors++; $display("FAIL reset_rfwr got=%b exp=0", RFWr); end
        checks++; if (instret !== 64'd0) begin errors++; $display("FAIL reset_instret got=%0d exp=0", instret); end
        checks++; if ({A3, WD, pc} !== '0) begin errors++; $display("FAIL reset_fields A3=%0d WD=%h pc=%h exp=0", A3, WD, pc); end
        rst = 1'b0;
        drive(1'b1, 32'h10, 5'd5, 1'b1, 2'b00, 3'b010, 32'h0000_1234, 32'h0, 32'h0);
        tick();
        checks++;
        if (RFWr !== 1'b1 || A3 !== 5'd5 || WD !== 32'h0000_1234 || pc !== 32'h10) begin
            errors++; $display("FAIL first_write RFWr=%b A3=%0d WD=%h pc=%h exp 1/5/00001234/10", RFWr, A3, WD, pc);
        end
        checks++;
        if (wb_fwd_valid !== 1'b1 || wb_fwd_rd !== 5'd5 || wb_fwd_data !== 32'h0000_1234) begin
            errors++; $display("FAIL fwd_port v=%b rd=%0d d=%h exp 1/5/00001234", wb_fwd_valid, wb_fwd_rd, wb_fwd_data);
        end
        checks++; if (instret !== 64'd0) begin errors++; $display("FAIL instret_latency got=%0d exp=0", instret); end
        exp_cnt = 64'd0;
    endtask

    task automatic test_x0_lui_jal();
        drive(1'b1, 32'h14, 5'd0, 1'b1, 2'b00, 3'b010, 32'h55, 32'h0, 32'h0);
        tick(); exp_cnt = exp_cnt + 1;
        checks++; if (instret !== exp_cnt) begin errors++; $display("FAIL instret_after_first got=%0d exp=%0d", instret, exp_cnt); end
        checks++; if (RFWr !== 1'b0 || wb_fwd_valid !== 1'b0) begin errors++; $display("FAIL x0_write RFWr=%b fwd=%b exp=0", RFWr, wb_fwd_valid); end
        drive(1'b1, 32'h18, 5'd3, 1'b1, 2'b11, 3'b010, 32'h0, 32'h0, 32'hABCD_E000);
        tick(); exp_cnt = exp_cnt + 1;
        checks++; if (instret !== exp_cnt) begin errors++; $display("FAIL x0_counted got=%0d exp=%0d", instret, exp_cnt); end
        checks++; if (WD !== 32'hABCD_E000 || RFWr !== 1'b1) begin errors++; $display("FAIL lui_wd got=%h RFWr=%b exp=abcde000/1", WD, RFWr); end
        drive(1'b1, 32'hFFFF_FFFC, 5'd1, 1'b1, 2'b10, 3'b010, 32'h0, 32'h0, 32'h0);
        tick(); exp_cnt = exp_cnt + 1;
        checks++; if (WD !== 32'h0000_0000 || pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL jal_wrap WD=%h pc=%h exp=00000000/fffffffc", WD, pc); end
        drive(1'b1, 32'h100, 5'd2, 1'b1, 2'b10, 3'b010, 32'h0, 32'h0, 32'h0);
        tick(); exp_cnt = exp_cnt + 1;
        checks++; if (WD !== 32'h0000_0104) begin errors++; $display("FAIL jal_pc4 WD=%h exp=00000104", WD); end
    endtask

    task automatic test_loads();
        logic [2:0]  dm_t  [7];
        logic [31:0] adr_t [7];
        logic [31:0] exp_t [7];
        dm_t[0] = 3'b000; adr_t[0] = 32'h1003;
        dm_t[1] = 3'b100; adr_t[1] = 32'h1003;
        dm_t[2] = 3'b001; adr_t[2] = 32'h1000;
        dm_t[3] = 3'b101; adr_t[3] = 32'h1002;
        dm_t[4] = 3'b001; adr_t[4] = 32'h1003;
        dm_t[5] = 3'b010; adr_t[5] = 32'h1000;
        dm_t[6] = 3'b111; adr_t[6] = 32'h1001;
`ifdef WB_LOAD_EXT_EN
        exp_t[0] = 32'hFFFF_FF80; exp_t[1] = 32'h0000_0080; exp_t[2] = 32'h0000_7F01;
        exp_t[3] = 32'h0000_80FF; exp_t[4] = 32'hFFFF_80FF; exp_t[5] = 32'h80FF_7F01;
        exp_t[6] = 32'h80FF_7F01;
`else
        for (int i = 0; i < 7; i++) exp_t[i] = 32'h80FF_7F01;
`endif
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, 32'h200 + 32'(4*i), 5'd10, 1'b1, 2'b01, dm_t[i], adr_t[i], 32'h80FF_7F01, 32'h0);
            tick(); exp_cnt = exp_cnt + 1;
            checks++;
            if (WD !== exp_t[i] || RFWr !== 1'b1) begin
                errors++; $display("FAIL load_%0d dm=%b addr=%h WD=%h exp=%h RFWr=%b", i, dm_t[i], adr_t[i], WD, exp_t[i], RFWr);
            end
        end
        checks++; if (instret !== exp_cnt) begin errors++; $display("FAIL load_instret got=%0d exp=%0d", instret, exp_cnt); end
    endtask

    task automatic test_stall();
        drive(1'b0, 32'h0, 5'd0, 1'b0, 2'b00, 3'b010, 32'h0, 32'h0, 32'h0);
        tick(); exp_cnt = exp_cnt + 1;
        drive(1'b1, 32'h300, 5'd9, 1'b1, 2'b00, 3'b010, 32'h0000_CAFE, 32'h0, 32'h0);
        tick();
        checks++; if (RFWr !== 1'b1 || WD !== 32'h0000_CAFE) begin errors++; $display("FAIL stall_load RFWr=%b WD=%h exp=1/0000cafe", RFWr, WD); end
        stall = 1'b1;
        drive(1'b1, 32'h304, 5'd11, 1'b1, 2'b11, 3'b000, 32'h1, 32'h2, 32'h3);
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (RFWr !== 1'b1 || A3 !== 5'd9 || WD !== 32'h0000_CAFE || pc !== 32'h300 || instret !== exp_cnt) begin
                errors++; $display("FAIL stall_hold_%0d RFWr=%b A3=%0d WD=%h pc=%h cnt=%0d exp 1/9/0000cafe/300/%0d", i, RFWr, A3, WD, pc, instret, exp_cnt);
            end
        end
        stall = 1'b0;
        drive(1'b0, 32'h0, 5'd0, 1'b0, 2'b00, 3'b010, 32'h0, 32'h0, 32'h0);
        tick(); exp_cnt = exp_cnt + 1;
        checks++; if (instret !== exp_cnt || RFWr !== 1'b0) begin errors++; $display("FAIL stall_release cnt=%0d exp=%0d RFWr=%b", instret, exp_cnt, RFWr); end
    endtask

    task automatic test_flush();
        drive(1'b1, 32'h400, 5'd4, 1'b1, 2'b00, 3'b010, 32'h0000_0444, 32'h0, 32'h0);
        tick();
        checks++; if (RFWr !== 1'b1 || A3 !== 5'd4) begin errors++; $display("FAIL flush_pre RFWr=%b A3=%0d exp=1/4", RFWr, A3); end
        flush = 1'b1; stall = 1'b1;
        tick();
        checks++; if (RFWr !== 1'b0 || instret !== exp_cnt) begin errors++; $display("FAIL flush_stall RFWr=%b cnt=%0d exp=0/%0d", RFWr, instret, exp_cnt); end
        flush = 1'b0; stall = 1'b0;
        drive(1'b0, 32'h0, 5'd0, 1'b0, 2'b00, 3'b010, 32'h0, 32'h0, 32'h0);
        tick();
        checks++; if (instret !== exp_cnt) begin errors++; $display("FAIL flush_no_count cnt=%0d exp=%0d", instret, exp_cnt); end
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 32'h500, 5'd12, 1'b1, 2'b00, 3'b010, 32'h1111_0000, 32'h0, 32'h0);
        tick();
        checks++; if (A3 !== 5'd12 || WD !== 32'h1111_0000) begin errors++; $display("FAIL b2b_0 A3=%0d WD=%h exp=12/11110000", A3, WD); end
        drive(1'b1, 32'h504, 5'd13, 1'b0, 2'b00, 3'b010, 32'h2222_0000, 32'h0, 32'h0);
        tick(); exp_cnt = exp_cnt + 1;
        checks++; if (RFWr !== 1'b0 || A3 !== 5'd13 || pc !== 32'h504) begin errors++; $display("FAIL b2b_nowr RFWr=%b A3=%0d pc=%h exp=0/13/504", RFWr, A3, pc); end
        drive(1'b0, 32'h0, 5'd0, 1'b0, 2'b00, 3'b010, 32'h0, 32'h0, 32'h0);
        tick(); exp_cnt = exp_cnt + 1;
        checks++; if (instret !== exp_cnt) begin errors++; $display("FAIL b2b_instret got=%0d exp=%0d", instret, exp_cnt); end
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 32'h600, 5'd6, 1'b1, 2'b00, 3'b010, 32'h66, 32'h0, 32'h0);
        tick();
        rst = 1'b1;
        tick();
        checks++; if (RFWr !== 1'b0 || instret !== 64'd0) begin errors++; $display("FAIL reset_mid RFWr=%b cnt=%0d exp=0/0", RFWr, instret); end
        rst = 1'b0;
        drive(1'b0, 32'h0, 5'd0, 1'b0, 2'b00, 3'b010, 32'h0, 32'h0, 32'h0);
        tick();
        checks++; if (RFWr !== 1'b0) begin errors++; $display("FAIL reset_after RFWr=%b exp=0", RFWr); end
    endtask

    initial begin
        test_reset();
        test_x0_lui_jal();
        test_loads();
        test_stall();
        test_flush();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_stage.md
# wb_stage

MEM/WB pipeline register and write-back selection for the pipelined RISC-V core. Captures the MEM-stage result each cycle, formats load data, selects the write-back value, and drives the register-file write port (`RFWr`, `A3`, `WD`, `pc`). It also exports the WB value to the forwarding unit and keeps a retired-instruction counter.

## Interface
Parameters:
- `XLEN`, 32, datapath width.
- `CNT_W`, 64, width of the retired-instruction counter.

Ports:
- `clk`  in  1  core clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `stall`  in  1  hold the WB register.
- `flush`  in  1  load a bubble into the WB register.
- `mem_valid`  in  1  MEM slot holds a real instruction.
- `mem_pc`  in  `ADDR_BUS`  PC of the MEM instruction.
- `mem_rd`  in  5  destination register.
- `mem_reg_wr`  in  1  instruction writes `rd`.
- `mem_wd_sel`  in  2  write-back source: 00 ALU, 01 load, 10 PC+4, 11 immediate (LUI).
- `mem_dm_type`  in  3  load funct3.
- `mem_alu_out`  in  XLEN  ALU result; also the load address.
- `mem_rdata`  in  XLEN  raw aligned data-memory word.
- `mem_imm`  in  XLEN  U-type immediate.
- `RFWr`  out  1  register-file write enable.
- `A3`  out  5  register-file write address.
- `WD`  out  XLEN  register-file write data.
- `pc`  out  `ADDR_BUS`  PC of the WB instruction, used for the write trace.
- `wb_fwd_valid`  out  1  equals `RFWr`; qualifies forwarding.
- `wb_fwd_rd`  out  5  equals `A3`.
- `wb_fwd_data`  out  XLEN  equals `WD`.
- `instret`  out  CNT_W  count of retired instructions.

## Operation
- **WB register contents:** valid, pc, rd, reg_wr, wd_sel, dm_type, alu_out, rdata, imm.
- **Register update priority** (highest first), applied on each rising edge:
  - `rst`: all fields go to 0.
  - `flush`: valid=0; other fields are don't-care. `flush` wins over `stall`.
  - `stall`: hold all fields.
  - Otherwise: load all fields from the `mem_*` inputs.
- **Write enable:** `RFWr = valid & reg_wr & (rd != 0)`. A write to x0 is never asserted.
- **`A3` and `pc`:** registered `rd` and registered `pc`, passed through unmodified.
- **`WD` source, by `wd_sel`:**
  - 00: `alu_out`.
  - 01: formatted load data.
  - 10: `pc + 4`, modulo 2^32.
  - 11: `imm`.
- **Load formatting** (byte offset `off = alu_out[1:0]`):
  - 000 LB: sign-extend `rdata[8*off +: 8]`.
  - 100 LBU: zero-extend `rdata[8*off +: 8]`.
  - 001 LH: sign-extend the halfword selected by `alu_out[1]`; `alu_out[0]` is ignored.
  - 101 LHU: zero-extend the same halfword.
  - 010 LW and unused codes 011/110/111: the whole `rdata`.
- **Retired-instruction counter:**
  - `instret` increments by 1 on every rising edge at which the WB register holds valid=1 and `stall`=0, whether or not the instruction writes a register.
  - It wraps at 2^CNT_W.
  - It resets to 0 and is unaffected by `flush`.

## Timing
- **Reset values:** `RFWr`=0, `A3`=0, `WD`=0, `pc`=0, `wb_fwd_*`=0, `instret`=0.
- **Latency:** inputs sampled at rising edge N appear on `RFWr`/`A3`/`WD`/`pc` from edge N until edge N+1. All outputs are combinational from the WB register only, with no input-to-output path.
- **RF write timing:** the register file writes on the falling edge inside that cycle. A same-cycle ID read of `A3` therefore sees the new value in the second half-cycle.
- **Stall:** the outputs repeat for every stalled cycle. The register file may rewrite the same value, which is harmless. `instret` does not advance.
- **Reset mid-operation:** the in-flight WB instruction is dropped and no write occurs in the reset cycle or the cycle after it.

## Configuration
- **`WB_LOAD_EXT_EN` defined:** full sub-word load formatting as above.
- **`WB_LOAD_EXT_EN` undefined:** `WD` for `wd_sel`=01 is always the raw `rdata` (LW only). `dm_type` is not registered, and the load-formatting logic is not instantiated.

## Structure
- **Shared header:**
  - The `ADDR_BUS` macro comes from the existing shared bus header.
  - The WB_SEL_ALU/MEM/PC4/IMM codes (00/01/10/11) go in a shared control-definitions header used by the decoder and this block.
  - The DM_LB/LH/LW/LBU/LHU codes go in the same header.
- **Sub-module:** `wb_load_ext`, purely combinational (`rdata`, `off`, `dm_type` → formatted word). It is instantiated only under `WB_LOAD_EXT_EN`.

## Test plan
- **Reset:** hold `rst` 2 cycles with `mem_valid`=1 → `RFWr`=0, `instret`=0. Release, send ALU write x5=0x0000_1234 at pc 0x0000_0010 → next cycle `RFWr`=1, `A3`=5, `WD`=0x0000_1234, `pc`=0x10; `instret`=1 one edge later.
- **x0 and LUI/JAL:**
  - `mem_rd`=0, `mem_reg_wr`=1 → `RFWr`=0, `instret` increments.
  - `wd_sel`=11, imm=0xABCD_E000 → `WD`=0xABCD_E000.
  - `wd_sel`=10, pc=0xFFFF_FFFC → `WD`=0x0000_0000.
- **Loads** (`rdata`=0x80FF_7F01):
  - LB off=3 → 0xFFFF_FF80.
  - LBU off=3 → 0x0000_0080.
  - LH off=0 → 0x0000_7F01.
  - LHU off=2 → 0x0000_80FF.
  - LH off=3 → 0xFFFF_80FF.
  - LW → 0x80FF_7F01.
- **Stall:** 3 stall cycles with a valid write → outputs constant for 4 cycles; `instret` rises by exactly 1.
- **Flush:** `flush` and `stall` both high → next cycle `RFWr`=0; `instret` unchanged.
- **Macro off:** build without `WB_LOAD_EXT_EN`, LB off=3 with `rdata`=0x80FF_7F01 → `WD`=0x80FF_7F01.
